// File: rtl/hazard_control_unit.sv
// hazard_control_unit: load-use stall, branch flush and debug halt control.
// Drives PC, IF/ID and ID/EX stall/flush strobes and keeps event counters.
module hazard_control_unit #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 16,
  parameter logic [1:0]  LSU          = 2'd1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       id_rs1_addr_i,
  input  logic [4:0]       id_rs2_addr_i,
  input  logic             id_rs1_used_i,
  input  logic             id_rs2_used_i,
  input  logic [4:0]       ex_reg_wr_addr_i,
  input  logic             ex_reg_wr_sig_i,
  input  logic [1:0]       ex_data_dest_i,
  input  logic             ex_br_taken_i,
  input  logic             dbg_halt_i,
  input  logic             clr_cnt_i,
  output logic             pc_stall_o,
  output logic             if_id_stall_o,
  output logic             if_id_flush_o,
  output logic             id_ex_stall_o,
  output logic             id_ex_flush_o,
  output logic             dbg_halted_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [1:0] FLUSH_LD = 2'(FLUSH_CYCLES);

  state_t           state;
  logic [1:0]       drain_cnt;
  logic [1:0]       shadow_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic             halted_q;

  logic br;
  logic shadow;
  logic hold;
  logic rs1_hit;
  logic rs2_hit;
  logic lu;
  logic stall;

  assign br      = ex_br_taken_i;
  assign shadow  = (shadow_cnt != 2'd0);
  assign hold    = (state != RUN);
  assign rs1_hit = id_rs1_used_i &&
                   (id_rs1_addr_i == ex_reg_wr_addr_i);
  assign rs2_hit = id_rs2_used_i &&
                   (id_rs2_addr_i == ex_reg_wr_addr_i);

  // Load in EX feeding ID; ignored while draining or in a branch shadow.
  assign lu = (state == RUN) && !shadow &&
              ex_reg_wr_sig_i &&
              (ex_data_dest_i == LSU) &&
              (ex_reg_wr_addr_i != 5'd0) &&
              (rs1_hit || rs2_hit);

  // A taken branch overrides any hold or load-use stall.
  assign stall = !br && (hold || lu);

  assign pc_stall_o    = reset_n && stall;
  assign if_id_stall_o = reset_n && stall && !shadow;
  assign if_id_flush_o = reset_n && (br || shadow);
  assign id_ex_stall_o = reset_n && stall;
  assign id_ex_flush_o = reset_n && br;

  assign dbg_halted_o = halted_q;
  assign stall_cnt_o  = stall_cnt;
  assign flush_cnt_o  = flush_cnt;

  // Debug halt FSM: drain three cycles, then freeze until released.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= RUN;
      drain_cnt <= 2'd0;
      halted_q  <= 1'b0;
    end else begin
      halted_q <= (state == HALTED);
      unique case (state)
        RUN: begin
          if (dbg_halt_i && !br) begin
            state     <= DRAIN;
            drain_cnt <= 2'd3;
          end
        end
        DRAIN: begin
          if (!dbg_halt_i) begin
            state <= RUN;
          end else if (br) begin
            drain_cnt <= 2'd3;
          end else if (drain_cnt == 2'd1) begin
            state     <= HALTED;
            drain_cnt <= 2'd0;
          end else begin
            drain_cnt <= drain_cnt - 2'd1;
          end
        end
        HALTED: begin
          if (!dbg_halt_i) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

  // Extra IF/ID flush cycles covering fetches already in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_cnt <= 2'd0;
    end else if (br) begin
      shadow_cnt <= FLUSH_LD;
    end else if (shadow) begin
      shadow_cnt <= shadow_cnt - 2'd1;
    end
  end

  // Saturating event counters; clear beats a same-cycle increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (clr_cnt_i) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (lu && !br && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
      if (br && (flush_cnt != '1))
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule
